claw_station_arbiter: RTL
=========================

# claw_station_arbiter

Two-station front end for the single claw mechanism. It banks coin credits per player station and grants the claw to one station at a time with round-robin fairness. It forwards only the owner's joystick for a bounded play window, then issues the grab and holds the claw until the grab/return cycle finishes. It sits between the two station panels and the main claw controller, replacing the direct Coin/Mov/Grab connections.

## Interface
- CREDIT_MAX, 7: saturation value of each station's credit counter.
- CW, 3: credit counter width; must satisfy 2^CW > CREDIT_MAX.
- PLAY_CYCLES, 10: maximum cycles the owner's joystick is forwarded; must be ≥ 1.
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Coin_0, Coin_1  in  1  one-cycle coin pulse from station 0 / 1.
- Mov_0, Mov_1  in  4  station joystick, bit order {l,r,f,b} = [3:0].
- Grab_0, Grab_1  in  1  station grab button, level.
- Origin  in  1  claw is at its home position, from the main controller.
- Start  out  1  one-cycle session-start pulse to the main controller.
- Mov  out  4  forwarded joystick, same bit order.
- Grab  out  1  one-cycle grab pulse to the main controller.
- Owner  out  1  station currently granted; valid while Busy.
- Busy  out  1  high in every state except IDLE.
- Credit_0, Credit_1  out  CW  banked credits per station.

## Operation
- States:
  - IDLE: if any credit is nonzero, pick a station, decrement its credit, load Owner, and go to START.
    - Only one station has credit: pick that station.
    - Both stations have credit: pick ~last_owner.
  - START: Start=1; clear play timer; go to PLAY.
  - PLAY: Mov = Mov_<Owner>; timer increments every cycle. If Grab_<Owner>=1 or timer == PLAY_CYCLES-1, go to GRAB.
  - GRAB: Grab=1, Mov=0; go to LEAVE.
  - LEAVE: Mov=0; wait for Origin=0, meaning the claw has departed home.
  - RETURN: Mov=0; on Origin=1, set last_owner=Owner and go to IDLE.
- Mov is 0 in every state except PLAY. Start and Grab are decoded from the state register only.
- Grab_<non-owner> and Mov_<non-owner> are ignored at all times.
- Credit update, per station, each cycle: next = credit + coin − dec, saturated at CREDIT_MAX.
  - Coin and decrement in the same cycle leave the credit unchanged, including at CREDIT_MAX.
  - A coin at CREDIT_MAX with no decrement is lost.
  - Coins are accepted in every state.
- Reset values:
  - state=IDLE; Credit_0=Credit_1=0; Owner=0; last_owner=1, so station 0 wins the first tie.
  - Start=Grab=Busy=0; Mov=0; timer=0.
- Reset mid-session aborts immediately and clears all banked credits.

## Timing
- Coin_k at cycle n: Credit_k incremented from n+1.
- IDLE with credit at cycle n: Start=1, Busy=1, Owner valid, credit decremented, all at n+1. PLAY begins at n+2.
- PLAY entered at cycle p:
  - Mov forwarded for cycles p … p+PLAY_CYCLES-1 at most.
  - Timeout gives Grab=1 at p+PLAY_CYCLES.
  - Grab_<Owner> sampled at cycle m gives Grab=1 at m+1; Mov is already 0 at m+1.
- Origin falling at cycle a moves to RETURN at a+1.
- Origin=1 sampled in RETURN at cycle r gives IDLE, Busy=0 at r+1. The next grant can start at r+2.
- Origin already 0 on entry to LEAVE: RETURN is entered next cycle; no deadlock.
- Mov is combinational from state, Owner and the station inputs. All other outputs are registered.

## Structure
- Package claw_pkg holds:
  - the state enum (IDLE, START, PLAY, GRAB, LEAVE, RETURN);
  - joystick bit-index constants MOV_L=3, MOV_R=2, MOV_F=1, MOV_B=0.
- Sub-module claw_credit_counter (ports: clk, Reset, inc, dec, count; parameters CREDIT_MAX, CW) is instantiated once per station.
- The FSM, timer and round-robin state stay in the top level.

## Test plan
- Reset, then Coin_0 pulse at cycle 2: Credit_0=1 at 3, Start=1/Owner=0/Credit_0=0 at 4, Mov follows Mov_0 from 5; Mov_1 never appears on Mov.
- Owner presses no grab: Mov is forwarded for exactly 10 cycles, then Grab=1 for one cycle and Mov=0 after.
- Owner grabs 3 cycles into PLAY: Grab=1 one cycle later. Grab_1 asserted during the session produces nothing.
- Both stations hold 2 credits: grant order across successive sessions is 0,1,0,1, each session closed by Origin 1→0→1.
- Eight Coin_1 pulses while idle-blocked (Busy): Credit_1 saturates at 7. Coin_1 coincident with a station-1 grant at 7: credit stays 7.
- Reset asserted in PLAY: same cycle Mov=0, Busy=0, credits 0. After release, no Start occurs without a new coin.

Source files
------------

// File: rtl/claw_pkg.sv
// Shared types and constants for the two-station claw front end.
package claw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    PLAY   = 3'd2,
    GRAB   = 3'd3,
    LEAVE  = 3'd4,
    RETURN = 3'd5
  } state_t;

  // Joystick bit positions within a 4-bit Mov bus.
  localparam int MOV_L = 3;
  localparam int MOV_R = 2;
  localparam int MOV_F = 1;
  localparam int MOV_B = 0;

endpackage

// File: rtl/claw_credit_counter.sv
// Per-station credit bank: +1 per coin, -1 per grant, saturating at CREDIT_MAX.
module claw_credit_counter #(
  parameter int CREDIT_MAX = 7,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX = CW'(CREDIT_MAX);

  // A coin arriving with a grant cancels out, so the count holds even at MAX.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && !dec && count != MAX) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/claw_station_arbiter.sv
// Two-station claw arbiter: credit banking, round-robin grant, bounded play
// window with joystick forwarding, then grab and wait for the claw to return.
module claw_station_arbiter
  import claw_pkg::*;
#(
  parameter int CREDIT_MAX  = 7,
  parameter int CW          = 3,
  parameter int PLAY_CYCLES = 10
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Coin_0,
  input  logic          Coin_1,
  input  logic [3:0]    Mov_0,
  input  logic [3:0]    Mov_1,
  input  logic          Grab_0,
  input  logic          Grab_1,
  input  logic          Origin,
  output logic          Start,
  output logic [3:0]    Mov,
  output logic          Grab,
  output logic          Owner,
  output logic          Busy,
  output logic [CW-1:0] Credit_0,
  output logic [CW-1:0] Credit_1
);

  localparam int TW = $clog2(PLAY_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PLAY_CYCLES - 1);

  state_t        state, state_nxt;
  logic          last_owner;
  logic [TW-1:0] timer;

  logic has_0, has_1, grant, pick, dec_0, dec_1;
  logic owner_grab;
  logic [3:0] owner_mov;

  assign has_0 = (Credit_0 != '0);
  assign has_1 = (Credit_1 != '0);
  assign grant = (state == IDLE) && (has_0 || has_1);
  // Tie goes to the station that did not play last; otherwise whoever has credit.
  assign pick  = (has_0 && has_1) ? ~last_owner : has_1;
  assign dec_0 = grant && !pick;
  assign dec_1 = grant && pick;

  assign owner_grab = Owner ? Grab_1 : Grab_0;
  assign owner_mov  = Owner ? Mov_1  : Mov_0;

  claw_credit_counter #(.CREDIT_MAX(CREDIT_MAX), .CW(CW)) u_credit_0 (
    .clk   (clk),
    .Reset (Reset),
    .inc   (Coin_0),
    .dec   (dec_0),
    .count (Credit_0)
  );

  claw_credit_counter #(.CREDIT_MAX(CREDIT_MAX), .CW(CW)) u_credit_1 (
    .clk   (clk),
    .Reset (Reset),
    .inc   (Coin_1),
    .dec   (dec_1),
    .count (Credit_1)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = START;
      START:   state_nxt = PLAY;
      PLAY:    if (owner_grab || timer == TIMER_LAST) state_nxt = GRAB;
      GRAB:    state_nxt = LEAVE;
      LEAVE:   if (!Origin) state_nxt = RETURN;
      RETURN:  if (Origin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Owner      <= 1'b0;
      last_owner <= 1'b1;
      timer      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) Owner <= pick;
      if (state == RETURN && Origin) last_owner <= Owner;
      if (state == START) timer <= '0;
      else if (state == PLAY) timer <= timer + 1'b1;
    end
  end

  assign Start = (state == START);
  assign Grab  = (state == GRAB);
  assign Busy  = (state != IDLE);
  assign Mov   = (state == PLAY) ? owner_mov : '0;

endmodule
